// File: rtl/cola_pkg.sv
// Shared definitions for the cola vending initiator: one-hot state encoding and default price.
package cola_pkg;

  localparam int DEFAULT_PRICE = 3;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    COIN      = 6'b000010,
    GAP       = 6'b000100,
    WAIT_COLA = 6'b001000,
    DONE      = 6'b010000,
    ERR       = 6'b100000
  } state_t;

endpackage

// File: rtl/cola_down_timer.sv
// Loadable down-counter with a zero flag; saturates at zero so a late decrement is harmless.
module cola_down_timer #(
  parameter int W = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/cola_buyer.sv
// Customer-side initiator: issues PRICE coin pulses per cola, waits for each cola pulse,
// and reports done or a timeout error once the whole order is served or abandoned.
module cola_buyer
  import cola_pkg::*;
#(
  parameter int ORDER_W  = 4,
  parameter int PRICE    = DEFAULT_PRICE,
  parameter int COIN_GAP = 1,
  parameter int TIMEOUT  = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               order_valid,
  input  logic [ORDER_W-1:0] order_cnt,
  output logic               order_ready,
  input  logic               pi_cola,
  output logic               po_money,
  output logic               busy,
  output logic [ORDER_W-1:0] cola_rcvd,
  output logic               done,
  output logic               err
);

  localparam int CW   = (PRICE > 1) ? $clog2(PRICE) : 1;
  localparam int TMAX = (COIN_GAP > TIMEOUT) ? COIN_GAP : TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t             state_reg, state_next;
  logic [ORDER_W-1:0] target_reg, target_next;
  logic [ORDER_W-1:0] cola_reg, cola_next;
  logic [CW-1:0]      coin_reg, coin_next;
  logic [ORDER_W-1:0] cola_inc;

  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]      tmr_val;

  // One timer serves both GAP and WAIT_COLA since the two states never overlap.
  cola_down_timer #(.W(TW)) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      cola_reg   <= '0;
      coin_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      cola_reg   <= cola_next;
      coin_reg   <= coin_next;
    end
  end

  assign cola_inc = cola_reg + ORDER_W'(1);

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    cola_next   = cola_reg;
    coin_next   = coin_reg;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = '0;
    case (state_reg)
      IDLE: begin
        if (order_valid) begin
          cola_next = '0;
          if (order_cnt != '0) begin
            target_next = order_cnt;
            coin_next   = '0;
            state_next  = COIN;
          end else begin
            state_next  = DONE;
          end
        end
      end
      COIN: begin
        if (coin_reg == CW'(PRICE - 1)) begin
          state_next = WAIT_COLA;
          tmr_load   = 1'b1;
          tmr_val    = TW'(TIMEOUT - 1);
        end else begin
          coin_next  = coin_reg + CW'(1);
          state_next = GAP;
          tmr_load   = 1'b1;
          tmr_val    = TW'(COIN_GAP - 1);
        end
      end
      GAP: begin
        if (tmr_zero) state_next = COIN;
        else          tmr_dec    = 1'b1;
      end
      WAIT_COLA: begin
        // A cola arriving on the last wait cycle still counts.
        if (pi_cola) begin
          cola_next = cola_inc;
          if (cola_inc == target_reg) begin
            state_next = DONE;
          end else begin
            coin_next  = '0;
            state_next = GAP;
            tmr_load   = 1'b1;
            tmr_val    = TW'(COIN_GAP - 1);
          end
        end else if (tmr_zero) begin
          state_next = ERR;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign order_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign po_money    = (state_reg == COIN);
  assign done        = (state_reg == DONE);
  assign err         = (state_reg == ERR);
  assign cola_rcvd   = cola_reg;

endmodule

// File: tb/tb_cola_buyer.sv
// Scoreboard bench for cola_buyer: stimulus queues expected coin/done/err events,
// a negedge monitor pops and checks them, a small vending model returns colas.
module tb_cola_buyer;

  localparam int K_COIN = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int cyc;
    int rcvd;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       order_valid = 1'b0;
  logic [3:0] order_cnt = '0;
  logic       order_ready;
  logic       pi_cola;
  logic       po_money;
  logic       busy;
  logic [3:0] cola_rcvd;
  logic       done;
  logic       err;

  logic model_cola = 1'b0;
  logic stray_cola = 1'b0;
  bit   model_on   = 1'b1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  assign pi_cola = model_cola | stray_cola;

  cola_buyer dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .order_valid (order_valid),
    .order_cnt   (order_cnt),
    .order_ready (order_ready),
    .pi_cola     (pi_cola),
    .po_money    (po_money),
    .busy        (busy),
    .cola_rcvd   (cola_rcvd),
    .done        (done),
    .err         (err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int rcvd);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.rcvd = rcvd;
    exp_q.push_back(e);
  endtask

  // Three coins per cola two cycles apart, cola answered one cycle after the last coin,
  // one gap cycle before the next cola's first coin: seven cycles per cola.
  task automatic push_order(input int a, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 3; j++)
        push(K_COIN, a + 7 * i + 1 + 2 * j, 0);
    push(K_DONE, a + 7 * n, n);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_output: got kind %0d at cycle %0d, required no output", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("out_kind", kind, e.kind);
      check("out_cycle", cyc, e.cyc);
      if (kind != K_COIN) check("out_rcvd", int'(cola_rcvd), e.rcvd);
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      if (po_money) observe(K_COIN);
      if (done)     observe(K_DONE);
      if (err)      observe(K_ERR);
    end
  end

  // Vending model: after every third coin, a one-cycle cola in the following cycle.
  int  model_coins = 0;
  bit  model_pend  = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      model_coins = 0;
      model_pend  = 1'b0;
      model_cola  = 1'b0;
    end else begin
      model_cola = model_pend;
      model_pend = 1'b0;
      if (po_money) begin
        model_coins++;
        if (model_coins == 3) begin
          model_coins = 0;
          model_pend  = model_on;
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input int n, output int a);
    check("accept_ready", int'(order_ready), 1);
    order_cnt   = 4'(n);
    order_valid = 1'b1;
    a = cyc;
    tick();
    order_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int a, input int ready_off, input int rcvd);
    int g = 0;
    while (!order_ready && g < 300) begin
      tick();
      g++;
    end
    if (!order_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: order_ready still 0 after %0d cycles, required 1", name, g);
    end else begin
      check({name, "_ready_cycle"}, cyc - a, ready_off);
      check({name, "_rcvd"}, int'(cola_rcvd), rcvd);
    end
  endtask

  initial begin
    int a;
    #1 sys_rst = 1'b0;
    #2;
    check("rst_order_ready", int'(order_ready), 1);
    check("rst_po_money", int'(po_money), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'({done, err}), 0);
    check("rst_cola_rcvd", int'(cola_rcvd), 0);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();

    // Single cola.
    issue(1, a);
    push_order(a, 1);
    wait_idle("order1", a, 8, 1);
    tick();
    check("order1_hold_rcvd", int'(cola_rcvd), 1);

    // Three colas.
    issue(3, a);
    push_order(a, 3);
    wait_idle("order3", a, 22, 3);

    // No cola ever returned: three coins, four wait cycles, error pulse.
    model_on = 1'b0;
    issue(2, a);
    for (int j = 0; j < 3; j++) push(K_COIN, a + 1 + 2 * j, 0);
    push(K_ERR, a + 10, 0);
    wait_idle("timeout", a, 11, 0);
    model_on = 1'b1;

    // Zero-cola order.
    issue(0, a);
    push(K_DONE, a + 1, 0);
    check("zero_busy_c1", int'(busy), 1);
    tick();
    check("zero_busy_c2", int'(busy), 0);
    wait_idle("zero", a, 2, 0);

    // Stray cola in IDLE.
    stray_cola = 1'b1;
    tick();
    stray_cola = 1'b0;
    tick();
    check("stray_idle_rcvd", int'(cola_rcvd), 0);
    check("stray_idle_ready", int'(order_ready), 1);

    // Stray cola in GAP and an order pulsed while busy.
    issue(1, a);
    push_order(a, 1);
    tick();
    stray_cola = 1'b1;
    tick();
    stray_cola = 1'b0;
    tick();
    order_cnt   = 4'd5;
    order_valid = 1'b1;
    tick();
    order_valid = 1'b0;
    wait_idle("stray_gap", a, 8, 1);
    tick();
    tick();
    check("no_second_order_busy", int'(busy), 0);

    // Maximum order.
    issue(15, a);
    push_order(a, 15);
    wait_idle("max", a, 106, 15);

    // Reset during the second coin's gap.
    issue(1, a);
    push(K_COIN, a + 1, 0);
    push(K_COIN, a + 3, 0);
    tick();
    tick();
    tick();
    check("pre_rst_busy", int'(busy), 1);
    sys_rst = 1'b0;
    #1;
    check("midrst_po_money", int'(po_money), 0);
    check("midrst_order_ready", int'(order_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done_err", int'({done, err}), 0);
    tick();
    sys_rst = 1'b1;
    tick();
    issue(1, a);
    push_order(a, 1);
    wait_idle("post_rst", a, 8, 1);

    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
